// File: rtl/unified_mem_ctrl_if.sv
// Fetch and load/store request/response bundle for unified_mem_ctrl.
//   master: requester side (core); drives req/addr/we/be/wdata, sees gnt and responses.
//   slave : controller side; drives gnt, rvalid, rdata and err.
//   if_*  : fetch channel (read only)
//   d_*   : load/store channel (read or byte-strobed write)
interface unified_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_err;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_err;

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
           d_gnt, d_rvalid, d_rdata, d_err
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
           d_gnt, d_rvalid, d_rdata, d_err
  );
endinterface

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data memory: one storage array shared by a fetch port and
// a load/store port, one access per cycle, responses returned in order through
// a fixed READ_LAT-stage pipeline.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : request/response bundle (slave side)
//   busy  : any response still in flight
module unified_mem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 10240,
  parameter int READ_LAT    = 1,
  parameter int DATA_PRIO   = 1
) (
  input  logic              clk,
  input  logic              reset,
  unified_mem_ctrl_if.slave bus,
  output logic              busy
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF   = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // port: 1 = load/store channel, 0 = fetch channel
  typedef struct packed {
    logic              port;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic [DATA_W-1:0]   mem [DEPTH_WORDS];

  logic [READ_LAT-1:0] vld_pipe;
  rsp_t                pipe [READ_LAT];
  logic                last_d;   // last granted port, 0 = fetch

  logic                if_gnt, d_gnt;
  logic                acc, acc_we, acc_err;
  logic [ADDR_W-1:0]   acc_addr, widx_full;
  logic [IDX_W-1:0]    widx;

  // Arbitration. Under round-robin the pointer starts at fetch, so the data
  // port takes the first conflict.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (bus.d_req && bus.if_req) begin
      if (DATA_PRIO != 0 || !last_d) d_gnt  = 1'b1;
      else                           if_gnt = 1'b1;
    end else begin
      d_gnt  = bus.d_req;
      if_gnt = bus.if_req;
    end
  end

  assign bus.if_gnt = if_gnt;
  assign bus.d_gnt  = d_gnt;

  // Grants are visible during reset but nothing is accepted.
  assign acc       = reset && (d_gnt || if_gnt);
  assign acc_addr  = d_gnt ? bus.d_addr : bus.if_addr;
  assign acc_we    = d_gnt && bus.d_we;
  assign widx_full = acc_addr >> OFF;
  assign widx      = widx_full[IDX_W-1:0];
  assign acc_err   = (|(acc_addr & ADDR_W'(NB - 1))) ||
                     (widx_full >= ADDR_W'(DEPTH_WORDS));

  // Storage is never reset; errored accesses leave it untouched.
  always_ff @(posedge clk) begin
    if (acc && acc_we && !acc_err) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.d_be[b]) mem[widx][b*8 +: 8] <= bus.d_wdata[b*8 +: 8];
      end
    end
  end

  // Response pipeline. Stage 0 captures the array at the accepting edge, so a
  // read one cycle after a write to the same word already sees the new bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      last_d   <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) pipe[i] <= '0;
    end else begin
      vld_pipe[0]  <= acc;
      pipe[0].port <= d_gnt;
      pipe[0].err  <= acc && acc_err;
      pipe[0].data <= (acc && !acc_we && !acc_err) ? mem[widx] : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pipe[i]     <= pipe[i-1];
      end
      if (acc) last_d <= d_gnt;
    end
  end

  logic vld_out;
  rsp_t rsp_out;

  assign vld_out = vld_pipe[READ_LAT-1];
  assign rsp_out = pipe[READ_LAT-1];
  assign busy    = |vld_pipe;

  assign bus.if_rvalid = vld_out && !rsp_out.port;
  assign bus.if_rdata  = bus.if_rvalid ? rsp_out.data : '0;
  assign bus.if_err    = bus.if_rvalid && rsp_out.err;

  assign bus.d_rvalid  = vld_out && rsp_out.port;
  assign bus.d_rdata   = bus.d_rvalid ? rsp_out.data : '0;
  assign bus.d_err     = bus.d_rvalid && rsp_out.err;

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed bench: three controllers share clk/reset.
//   ua: READ_LAT=1, fixed data priority
//   ub: READ_LAT=1, round-robin
//   uc: READ_LAT=3, fixed data priority
module tb_unified_mem_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  unified_mem_ctrl_if ia ();
  unified_mem_ctrl_if ib ();
  unified_mem_ctrl_if ic ();
  logic busy_a, busy_b, busy_c;

  unified_mem_ctrl #(.READ_LAT(1), .DATA_PRIO(1)) ua (.clk(clk), .reset(reset), .bus(ia), .busy(busy_a));
  unified_mem_ctrl #(.READ_LAT(1), .DATA_PRIO(0)) ub (.clk(clk), .reset(reset), .bus(ib), .busy(busy_b));
  unified_mem_ctrl #(.READ_LAT(3), .DATA_PRIO(1)) uc (.clk(clk), .reset(reset), .bus(ic), .busy(busy_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    ia.if_req = 0; ia.if_addr = 0; ia.d_req = 0; ia.d_we = 0; ia.d_be = 0; ia.d_addr = 0; ia.d_wdata = 0;
    ib.if_req = 0; ib.if_addr = 0; ib.d_req = 0; ib.d_we = 0; ib.d_be = 0; ib.d_addr = 0; ib.d_wdata = 0;
    ic.if_req = 0; ic.if_addr = 0; ic.d_req = 0; ic.d_we = 0; ic.d_be = 0; ic.d_addr = 0; ic.d_wdata = 0;
  endtask

  // Lone data access on ua; response checked right after the accepting edge.
  task automatic a_d(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] erd, input logic eer,
                     input string tag);
    @(negedge clk);
    ia.d_req = 1; ia.d_we = we; ia.d_be = be; ia.d_addr = addr; ia.d_wdata = wd;
    #1 chk({tag, "_gnt"}, ia.d_gnt, 1);
    @(posedge clk);
    #1;
    chk({tag, "_rv"},  ia.d_rvalid, 1);
    chk({tag, "_rd"},  ia.d_rdata,  erd);
    chk({tag, "_err"}, ia.d_err,    eer);
    ia.d_req = 0;
  endtask

  task automatic a_f(input logic [31:0] addr, input logic [31:0] erd, input string tag);
    @(negedge clk);
    ia.if_req = 1; ia.if_addr = addr;
    #1 chk({tag, "_pre_rv"}, ia.if_rvalid, 0);
    @(posedge clk);
    #1;
    chk({tag, "_rv"},  ia.if_rvalid, 1);
    chk({tag, "_rd"},  ia.if_rdata,  erd);
    chk({tag, "_err"}, ia.if_err,    0);
    ia.if_req = 0;
  endtask

  logic [3:0] da_seq, fa_seq, db_seq, fb_seq;

  initial begin
    idle_all();
    #3 reset = 1'b0;
    #9;
    chk("rst_busy_a", busy_a,       0);
    chk("rst_busy_c", busy_c,       0);
    chk("rst_rv_a",   ia.d_rvalid,  0);
    chk("rst_rd_a",   ia.d_rdata,   0);
    chk("rst_err_c",  ic.d_err,     0);
    chk("rst_frv_b",  ib.if_rvalid, 0);
    @(negedge clk) reset = 1'b1;

    // basic write / fetch, byte strobe, errors
    a_d(1, 4'hF, 32'h0, 32'h11223344, 32'h0, 0, "wr0");
    a_f(32'h0, 32'h11223344, "fetch0");
    a_d(1, 4'b0010, 32'h0, 32'h0000AB00, 32'h0, 0, "wr_be");
    a_d(0, 4'h0, 32'h0, 32'h0, 32'h1122AB44, 0, "rd_be");
    a_d(0, 4'h0, 32'h6, 32'h0, 32'h0, 1, "rd_mis");
    a_d(0, 4'h0, 32'hA000, 32'h0, 32'h0, 1, "rd_oor");
    a_d(1, 4'hF, 32'h2, 32'hFFFFFFFF, 32'h0, 1, "wr_mis");
    a_d(1, 4'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 0, "wr_be0");
    a_d(0, 4'h0, 32'h0, 32'h0, 32'h1122AB44, 0, "rd_keep");

    // conflicts held for 4 cycles on ua (fixed) and ub (round-robin)
    @(negedge clk);
    ia.if_req = 1; ia.if_addr = 0; ia.d_req = 1; ia.d_we = 0; ia.d_addr = 0;
    ib.if_req = 1; ib.if_addr = 0; ib.d_req = 1; ib.d_we = 0; ib.d_addr = 0;
    da_seq = 0; fa_seq = 0; db_seq = 0; fb_seq = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      da_seq = {da_seq[2:0], ia.d_gnt};
      fa_seq = {fa_seq[2:0], ia.if_gnt};
      db_seq = {db_seq[2:0], ib.d_gnt};
      fb_seq = {fb_seq[2:0], ib.if_gnt};
      @(negedge clk);
    end
    idle_all();
    chk("prio_d", {28'h0, da_seq}, 32'hF);
    chk("prio_f", {28'h0, fa_seq}, 32'h0);
    chk("rr_d",   {28'h0, db_seq}, 32'hA);
    chk("rr_f",   {28'h0, fb_seq}, 32'h5);
    @(posedge clk); #1;
    chk("busy_a_idle", busy_a, 0);
    chk("busy_b_idle", busy_b, 0);

    // READ_LAT=3: fill three words, then three back-to-back reads
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ic.d_req = 1; ic.d_we = 1; ic.d_be = 4'hF; ic.d_addr = 32'(4 * i); ic.d_wdata = 32'hA0A00000 + 32'(i);
      @(posedge clk);
    end
    @(negedge clk) idle_all();
    repeat (4) @(posedge clk);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 3) begin
        ic.d_req = 1; ic.d_we = 0; ic.d_addr = 32'(4 * c);
      end else begin
        ic.d_req = 0;
      end
      @(posedge clk); #1;
      chk($sformatf("lat3_rv%0d", c), ic.d_rvalid, (c >= 2 && c <= 4) ? 1 : 0);
      chk($sformatf("lat3_rd%0d", c), ic.d_rdata,
          (c >= 2 && c <= 4) ? 32'hA0A00000 + 32'(c - 2) : 32'h0);
      chk($sformatf("lat3_busy%0d", c), busy_c, (c <= 4) ? 1 : 0);
    end

    // reset with two reads in flight
    @(negedge clk);
    ic.d_req = 1; ic.d_we = 0; ic.d_addr = 32'h0;
    @(negedge clk);
    ic.d_addr = 32'h4;
    @(posedge clk); #1;
    chk("inflight_busy", busy_c, 1);
    ic.d_req = 0;
    #1 reset = 1'b0;
    #1;
    chk("rst_busy_drop", busy_c, 0);
    chk("rst_rv_drop",   ic.d_rvalid, 0);
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_rv%0d", k), ic.d_rvalid, 0);
    end
    @(negedge clk);
    ic.d_req = 1; ic.d_we = 0; ic.d_addr = 32'h4;
    @(posedge clk); #1;
    ic.d_req = 0;
    @(posedge clk); #1;
    chk("retain_c_early", ic.d_rvalid, 0);
    @(posedge clk); #1;
    chk("retain_c_rv", ic.d_rvalid, 1);
    chk("retain_c_rd", ic.d_rdata,  32'hA0A00001);
    a_d(0, 4'h0, 32'h0, 32'h0, 32'h1122AB44, 0, "retain_a");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
